posit_req_arbiter: RTL

Shares one `posit_top` unit between `NUM_REQ` independent requesters, such as a scalar pipeline and a vector lane. The block arbitrates issue round-robin and drives the unit's input handshake. It keeps an in-order FIFO of requester IDs for in-flight operations and steers each result and status back to the requester that issued it. The block sits between the issuing pipelines and `posit_top` and contains no arithmetic.

---
 rtl/posit_req_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/posit_req_arbiter.sv
// posit_req_arbiter
//   Shares one posit_top unit between NUM_REQ requesters. Issue is arbitrated
//   round-robin. An in-order FIFO of requester IDs steers each returning
//   result/status back to the requester that issued it. The block has no
//   arithmetic and no pipeline stage: issue and return paths are combinational.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i/ready_o     per-requester issue handshake
//   req_operands_i/op_i/
//   req_op_mod_i/rnd_i      per-requester payload
//   rsp_valid_o/ready_i     per-requester result handshake
//   rsp_result_o/status_o   shared result/status bus (pass-through from unit)
//   pu_in_*/pu_operands_o/
//   pu_op_o/op_mod_o/rnd_o  unit input side, payload of granted requester
//   pu_out_*/pu_result_i/
//   pu_status_i             unit output side
//   pu_flush_o              flush forwarded to unit
//   flush_i                 abort all in-flight work
//   busy_o                  request pending or operation outstanding
//   err_o                   sticky: unit returned a result with no ID queued
module posit_req_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int OP_W    = 4,
    parameter int RND_W   = 3,
    parameter int ST_W    = 5
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][2:0][WIDTH-1:0]   req_operands_i,
    input  logic [NUM_REQ-1:0][OP_W-1:0]         req_op_i,
    input  logic [NUM_REQ-1:0]                   req_op_mod_i,
    input  logic [NUM_REQ-1:0][RND_W-1:0]        req_rnd_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    input  logic [NUM_REQ-1:0]                   rsp_ready_i,
    output logic [WIDTH-1:0]                     rsp_result_o,
    output logic [ST_W-1:0]                      rsp_status_o,
    output logic                                 pu_in_valid_o,
    input  logic                                 pu_in_ready_i,
    output logic [2:0][WIDTH-1:0]                pu_operands_o,
    output logic [OP_W-1:0]                      pu_op_o,
    output logic                                 pu_op_mod_o,
    output logic [RND_W-1:0]                     pu_rnd_o,
    input  logic                                 pu_out_valid_i,
    output logic                                 pu_out_ready_o,
    input  logic [WIDTH-1:0]                     pu_result_i,
    input  logic [ST_W-1:0]                      pu_status_i,
    output logic                                 pu_flush_o,
    input  logic                                 flush_i,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef logic [IDW-1:0] id_t;
    typedef logic [PW-1:0]  ptr_t;

    id_t             r_rr_ptr;
    logic            r_lock;
    id_t             r_lock_id;
    id_t             r_fifo [DEPTH];
    ptr_t            r_wr_ptr;
    ptr_t            r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_err;

    logic            w_gnt_vld;
    id_t             w_gnt;
    id_t             w_gnt_nxt;
    int              w_idx;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    id_t             w_head;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Walk from the lowest priority slot to the highest so the last hit
    // (closest to r_rr_ptr) wins. A held lock pins the grant so valid and
    // payload stay stable while the unit stalls.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = 0;
        if (r_lock) begin
            w_gnt_vld = 1'b1;
            w_gnt     = r_lock_id;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                w_idx = int'(r_rr_ptr) + k;
                if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
                if (req_valid_i[id_t'(w_idx)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = id_t'(w_idx);
                end
            end
        end
    end

    assign w_gnt_nxt = (w_gnt == id_t'(NUM_REQ - 1)) ? '0 : w_gnt + id_t'(1);
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_head    = r_fifo[r_rd_ptr];

    // Full check uses the registered count only: a same-cycle pop does not
    // free a slot for issue.
    assign pu_in_valid_o = w_gnt_vld && !w_full && !flush_i;
    assign w_push        = pu_in_valid_o && pu_in_ready_i;
    assign pu_operands_o = req_operands_i[w_gnt];
    assign pu_op_o       = req_op_i[w_gnt];
    assign pu_op_mod_o   = req_op_mod_i[w_gnt];
    assign pu_rnd_o      = req_rnd_i[w_gnt];

    always_comb begin
        req_ready_o = '0;
        if (w_push) req_ready_o[w_gnt] = 1'b1;
    end

    always_comb begin
        rsp_valid_o = '0;
        if (!w_empty && pu_out_valid_i) rsp_valid_o[w_head] = 1'b1;
    end

    // With nothing queued the unit's result has no owner: accept and drop it.
    assign pu_out_ready_o = w_empty ? pu_out_valid_i : rsp_ready_i[w_head];
    assign w_pop          = !w_empty && pu_out_valid_i && rsp_ready_i[w_head];

    assign rsp_result_o = pu_result_i;
    assign rsp_status_o = pu_status_i;
    assign pu_flush_o   = flush_i;
    assign busy_o       = (|req_valid_i) || !w_empty;
    assign err_o        = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr  <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_empty && pu_out_valid_i) r_err <= 1'b1;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_lock   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                    r_rr_ptr <= w_gnt_nxt;
                    r_lock   <= 1'b0;
                end else if (pu_in_valid_o) begin
                    r_lock    <= 1'b1;
                    r_lock_id <= w_gnt;
                end
                if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // ID storage needs no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i && !rst_i) r_fifo[r_wr_ptr] <= w_gnt;
    end

endmodule
